// File: rtl/sseg_pkg.sv
// Shared constants and helpers for the multiplexed seven-segment driver.
// Segment patterns are active-low and ordered {g,f,e,d,c,b,a}.
package sseg_pkg;

    localparam logic [6:0] SEG_BLANK  = 7'h7F;
    localparam int         MAX_DIGITS = 8;

    // Width of the scan index; a single-digit display still needs one bit.
    function automatic int idx_width(input int num_digits);
        if (num_digits <= 1) begin
            return 1;
        end else begin
            return $clog2(num_digits);
        end
    endfunction

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        logic [6:0] pattern;
        case (nibble)
            4'h0:    pattern = 7'b1000000;
            4'h1:    pattern = 7'b1111001;
            4'h2:    pattern = 7'b0100100;
            4'h3:    pattern = 7'b0110000;
            4'h4:    pattern = 7'b0011001;
            4'h5:    pattern = 7'b0010010;
            4'h6:    pattern = 7'b0000010;
            4'h7:    pattern = 7'b1111000;
            4'h8:    pattern = 7'b0000000;
            4'h9:    pattern = 7'b0010000;
            4'hA:    pattern = 7'b0001000;
            4'hB:    pattern = 7'b0000011;
            4'hC:    pattern = 7'b1000110;
            4'hD:    pattern = 7'b0100001;
            4'hE:    pattern = 7'b0000110;
            4'hF:    pattern = 7'b0001110;
            default: pattern = SEG_BLANK;
        endcase
        return pattern;
    endfunction

endpackage

// File: rtl/sseg_hex_decode.sv
// Combinational hex nibble to active-low seven-segment pattern.
module sseg_hex_decode
    import sseg_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    // Table lookup shared with the package so every user decodes identically.
    always_comb begin
        seg_o = hex_to_seg(nibble_i);
    end

endmodule

// File: rtl/sseg_scan_driver.sv
// Time-multiplexed common-anode seven-segment driver with PWM dimming,
// optional leading-zero suppression and frame-synchronous double buffering.
module sseg_scan_driver
    import sseg_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int DUTY_WIDTH  = 4,
    parameter int LZ_SUPPRESS = 0
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic                    load,
    input  logic [DUTY_WIDTH-1:0]   brightness,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int                    IDX_W     = idx_width(NUM_DIGITS);
    localparam int                    PRE_W     = $clog2(REFRESH_DIV);
    localparam logic [PRE_W-1:0]      PRE_LAST  = PRE_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [DUTY_WIDTH-1:0] DUTY_FULL = {DUTY_WIDTH{1'b1}};

    logic [PRE_W-1:0]        presc_q, presc_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [DUTY_WIDTH-1:0]   pwm_q, pwm_d;
    logic [4*NUM_DIGITS-1:0] pend_dig_q, pend_dig_d, disp_dig_q, disp_dig_d;
    logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d, disp_dp_q, disp_dp_d;
    logic [NUM_DIGITS-1:0]   pend_blank_q, pend_blank_d, disp_blank_q, disp_blank_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic                    frame_done_q, frame_done_d;

    logic                    tc_s;
    logic                    frame_s;
    logic                    all_zero_s;
    logic [NUM_DIGITS-1:0]   lz_s;
    logic [3:0]              cur_nib_s;
    logic                    cur_dp_s;
    logic                    dark_s;
    logic                    gate_s;
    logic [6:0]              dec_seg_s;

    sseg_hex_decode u_hex_decode (
        .nibble_i (cur_nib_s),
        .seg_o    (dec_seg_s)
    );

    // Scan timing, PWM counter and the pending/display double buffer.
    always_comb begin
        tc_s    = (presc_q == PRE_LAST);
        frame_s = tc_s && (idx_q == IDX_LAST);
        presc_d = tc_s ? {PRE_W{1'b0}} : presc_q + PRE_W'(1);
        pwm_d   = pwm_q + DUTY_WIDTH'(1);

        if (!tc_s) begin
            idx_d = idx_q;
        end else if (idx_q == IDX_LAST) begin
            idx_d = {IDX_W{1'b0}};
        end else begin
            idx_d = idx_q + IDX_W'(1);
        end

        if (load) begin
            pend_dig_d   = digits_in;
            pend_dp_d    = dp_in;
            pend_blank_d = blank_in;
        end else begin
            pend_dig_d   = pend_dig_q;
            pend_dp_d    = pend_dp_q;
            pend_blank_d = pend_blank_q;
        end

        // Taking pend_*_d here gives a load on the boundary cycle the bypass path.
        if (frame_s) begin
            disp_dig_d   = pend_dig_d;
            disp_dp_d    = pend_dp_d;
            disp_blank_d = pend_blank_d;
        end else begin
            disp_dig_d   = disp_dig_q;
            disp_dp_d    = disp_dp_q;
            disp_blank_d = disp_blank_q;
        end
    end

    // Output decode from next-state values so seg, an and frame_done move on one edge.
    always_comb begin
        lz_s       = {NUM_DIGITS{1'b0}};
        all_zero_s = 1'b1;
        cur_nib_s  = 4'h0;
        cur_dp_s   = 1'b0;
        dark_s     = 1'b1;
        an_d       = {NUM_DIGITS{1'b1}};
        gate_s     = (brightness == DUTY_FULL) || (pwm_d < brightness);

        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            all_zero_s = all_zero_s && (disp_dig_d[4*i +: 4] == 4'h0);
            lz_s[i]    = (LZ_SUPPRESS != 0) && all_zero_s && (i != 0);
        end

        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_d == IDX_W'(i)) begin
                cur_nib_s = disp_dig_d[4*i +: 4];
                cur_dp_s  = disp_dp_d[i];
                dark_s    = disp_blank_d[i] || lz_s[i];
                an_d[i]   = !gate_s;
            end else begin
                an_d[i]   = 1'b1;
            end
        end

        seg_d        = dark_s ? SEG_BLANK : dec_seg_s;
        dp_d         = dark_s ? 1'b1 : !cur_dp_s;
        frame_done_d = frame_s;
    end

    // State and output registers; reset leaves the display dark and buffers blanked.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            presc_q      <= {PRE_W{1'b0}};
            idx_q        <= {IDX_W{1'b0}};
            pwm_q        <= {DUTY_WIDTH{1'b0}};
            pend_dig_q   <= {(4*NUM_DIGITS){1'b0}};
            pend_dp_q    <= {NUM_DIGITS{1'b0}};
            pend_blank_q <= {NUM_DIGITS{1'b1}};
            disp_dig_q   <= {(4*NUM_DIGITS){1'b0}};
            disp_dp_q    <= {NUM_DIGITS{1'b0}};
            disp_blank_q <= {NUM_DIGITS{1'b1}};
            seg_q        <= SEG_BLANK;
            dp_q         <= 1'b1;
            an_q         <= {NUM_DIGITS{1'b1}};
            frame_done_q <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            pwm_q        <= pwm_d;
            pend_dig_q   <= pend_dig_d;
            pend_dp_q    <= pend_dp_d;
            pend_blank_q <= pend_blank_d;
            disp_dig_q   <= disp_dig_d;
            disp_dp_q    <= disp_dp_d;
            disp_blank_q <= disp_blank_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            an_q         <= an_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign an         = an_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Self-checking bench: two drivers (plain and leading-zero suppressing) against
// a cycle-count based reference model of the scan, PWM and frame buffering.
module tb_sseg_scan_driver;

    localparam int ND   = 4;
    localparam int RDIV = 4;
    localparam int DW   = 4;
    localparam int FRAME = ND * RDIV;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] digits_in = 16'h0000;
    logic [3:0]  dp_in = 4'h0;
    logic [3:0]  blank_in = 4'h0;
    logic        load = 1'b0;
    logic [3:0]  brightness = 4'h0;

    logic [6:0]  seg0, seg1;
    logic        dp0, dp1;
    logic [3:0]  an0, an1;
    logic        fd0, fd1;

    int checks = 0;
    int errors = 0;

    // Model state: k = clock edges since reset release.
    int          k = 0;
    logic [15:0] pend_dig = 16'h0000, disp_dig = 16'h0000;
    logic [3:0]  pend_dp = 4'h0, disp_dp = 4'h0;
    logic [3:0]  pend_bl = 4'hF, disp_bl = 4'hF;

    always #5 clock = ~clock;

    sseg_scan_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(RDIV), .DUTY_WIDTH(DW), .LZ_SUPPRESS(0)) dut (
        .clock(clock), .reset(reset), .digits_in(digits_in), .dp_in(dp_in),
        .blank_in(blank_in), .load(load), .brightness(brightness),
        .seg(seg0), .dp(dp0), .an(an0), .frame_done(fd0)
    );

    sseg_scan_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(RDIV), .DUTY_WIDTH(DW), .LZ_SUPPRESS(1)) dut_lz (
        .clock(clock), .reset(reset), .digits_in(digits_in), .dp_in(dp_in),
        .blank_in(blank_in), .load(load), .brightness(brightness),
        .seg(seg1), .dp(dp1), .an(an1), .frame_done(fd1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s k=%0d observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    function automatic logic [6:0] hex_seg(input logic [3:0] n);
        logic [6:0] t [16];
        t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        return t[n];
    endfunction

    task automatic expect_out(input bit lz, output logic [6:0] s, output logic d,
                              output logic [3:0] a, output logic f);
        int idx;
        int pw;
        bit gate;
        bit dark;
        if (k == 0) begin
            s = 7'h7F; d = 1'b1; a = 4'hF; f = 1'b0;
        end else begin
            idx  = (k / RDIV) % ND;
            pw   = k % 16;
            gate = (brightness == 4'hF) || (pw < int'(brightness));
            dark = disp_bl[idx] || (lz && idx != 0 && ((disp_dig >> (4 * idx)) == 16'h0000));
            s    = dark ? 7'h7F : hex_seg(disp_dig[4*idx +: 4]);
            d    = dark ? 1'b1 : ~disp_dp[idx];
            a    = gate ? ~(4'b0001 << idx) : 4'hF;
            f    = ((k % FRAME) == 0);
        end
    endtask

    task automatic check_all();
        logic [6:0] es;
        logic       ed;
        logic [3:0] ea;
        logic       ef;
        expect_out(1'b0, es, ed, ea, ef);
        check("seg", 32'(seg0), 32'(es));
        check("dp", 32'(dp0), 32'(ed));
        check("an", 32'(an0), 32'(ea));
        check("frame_done", 32'(fd0), 32'(ef));
        expect_out(1'b1, es, ed, ea, ef);
        check("lz_seg", 32'(seg1), 32'(es));
        check("lz_dp", 32'(dp1), 32'(ed));
        check("lz_an", 32'(an1), 32'(ea));
        check("lz_frame_done", 32'(fd1), 32'(ef));
    endtask

    // One clock: model the edge, check just after it, release load at the falling edge.
    task automatic cycle();
        @(posedge clock);
        k++;
        if (load) begin
            pend_dig = digits_in; pend_dp = dp_in; pend_bl = blank_in;
        end
        if ((k % FRAME) == 0) begin
            disp_dig = pend_dig; disp_dp = pend_dp; disp_bl = pend_bl;
        end
        #1;
        check_all();
        @(negedge clock);
        load = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b);
        digits_in = d; dp_in = p; blank_in = b; load = 1'b1;
        cycle();
    endtask

    task automatic wait_phase(input int ph);
        for (int i = 0; i < FRAME && (k % FRAME) != ph; i++) cycle();
    endtask

    task automatic model_reset();
        k = 0;
        pend_dig = 16'h0000; pend_dp = 4'h0; pend_bl = 4'hF;
        disp_dig = 16'h0000; disp_dp = 4'h0; disp_bl = 4'hF;
    endtask

    initial begin
        int on_cnt;
        repeat (3) @(negedge clock);
        check("rst_an", 32'(an0), 32'hF);
        check("rst_seg", 32'(seg0), 32'h7F);
        check("rst_dp", 32'(dp0), 32'h1);
        check("rst_fd", 32'(fd0), 32'h0);
        model_reset();
        reset = 1'b0;

        // Dark after reset, frame_done every 16 cycles.
        run(40);

        // Directed pattern from the datasheet example.
        brightness = 4'hF;
        do_load(16'h3A0F, 4'b0100, 4'b0000);
        run(40);

        // Load while digit 1 is shown, then a load on the boundary cycle.
        wait_phase(5);
        do_load(16'h1234, 4'b0001, 4'b0000);
        run(12);
        wait_phase(15);
        do_load(16'hBEEF, 4'b1000, 4'b0010);
        run(20);

        // Leading-zero suppression cases.
        do_load(16'h0050, 4'b0000, 4'b0000);
        run(36);
        do_load(16'h0000, 4'b0000, 4'b0000);
        run(36);

        // PWM: brightness 4 gives four lit cycles per sixteen.
        brightness = 4'h4;
        run(3);
        on_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            cycle();
            if (an0 != 4'hF) on_cnt++;
        end
        check("pwm_on_cnt", 32'(on_cnt), 32'd4);
        brightness = 4'h0;
        run(20);

        // Randomised traffic.
        for (int i = 0; i < 900; i++) begin
            if ($urandom_range(7) == 0) begin
                digits_in = 16'($urandom) >> (4 * $urandom_range(4));
                dp_in     = 4'($urandom);
                blank_in  = ($urandom_range(3) == 0) ? 4'($urandom) : 4'h0;
                load      = 1'b1;
            end
            if ($urandom_range(31) == 0) brightness = 4'($urandom_range(15));
            cycle();
        end

        // Reset mid-frame: immediately dark, then dark until a new load lands.
        brightness = 4'hF;
        do_load(16'h8888, 4'hF, 4'h0);
        run(20);
        @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        check("async_an", 32'(an0), 32'hF);
        check("async_seg", 32'(seg0), 32'h7F);
        check("async_dp", 32'(dp0), 32'h1);
        check("async_fd", 32'(fd0), 32'h0);
        @(negedge clock);
        @(negedge clock);
        model_reset();
        reset = 1'b0;
        run(36);
        do_load(16'h9C2D, 4'b0010, 4'b0000);
        run(40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sseg_scan_driver.md
Name: sseg_scan_driver

Overview:
Parametrised, time-multiplexed common-anode seven-segment driver for NUM_DIGITS digits.
- Full hex decode (0-F), per-digit decimal point and blanking, optional leading-zero suppression.
- PWM brightness control.
- Tear-free double-buffered loading: new values take effect only at a frame boundary.
- Sits between user logic (counters, switch readers, rover telemetry) and the board display pins.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (1..8)
REFRESH_DIV, 100000, clock cycles per digit slot (100 MHz -> 1 kHz per digit); minimum 2
DUTY_WIDTH, 4, width of brightness control and PWM counter
LZ_SUPPRESS, 0, 1 = blank leading zero digits (digit 0 never suppressed)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high
digits_in  in  4*NUM_DIGITS  hex nibble per digit; digit i on [4i+3:4i]; digit 0 rightmost
dp_in  in  NUM_DIGITS  1 = light decimal point of digit i
blank_in  in  NUM_DIGITS  1 = force digit i dark
load  in  1  one-cycle strobe: capture digits_in/dp_in/blank_in into pending buffer
brightness  in  DUTY_WIDTH  0 = off, all-ones = fully on
seg  out  7  active-low segments, ordered {g,f,e,d,c,b,a}
dp  out  1  active-low decimal point
an  out  NUM_DIGITS  active-low anode enables, one-hot-low
frame_done  out  1  one-cycle pulse at each frame boundary

Behaviour:
- Reset is asynchronous, active-high, clock is `clock`. During/after reset:
  - an = all ones, seg = 7'h7F, dp = 1, frame_done = 0.
  - Prescaler = 0, digit index = 0, PWM counter = 0.
  - Pending and display buffers: digits 0, dp 0, blank all ones. The display is dark until the first load has been transferred.
- Prescaler counts 0..REFRESH_DIV-1 and wraps. At terminal count the digit index advances (0,1,..,NUM_DIGITS-1,0).
- Frame boundary = the cycle where the prescaler is at terminal count and index = NUM_DIGITS-1.
  - frame_done is asserted one cycle later, aligned with the registered outputs switching to digit 0.
  - The pending buffer is copied into the display buffer at the frame boundary.
- load captures inputs into the pending buffer on that edge.
  - If load coincides with a frame boundary, the display buffer receives the newly loaded values directly (bypass).
  - Repeated loads within a frame: last one wins. A load never alters the digit being shown mid-frame.
- PWM counter (DUTY_WIDTH bits) free-runs, incrementing every cycle and wrapping.
  - Anode gate = (brightness == all ones) OR (pwm_cnt < brightness).
  - brightness 0 means an stays all ones.
- Leading-zero suppression (LZ_SUPPRESS=1): digit i is suppressed if all display digits j >= i have value 0 and i != 0.
- Digit dark condition: display blank[i] set, or digit i is suppressed.
  - Dark digit: seg = 7'h7F and dp = 1. Its anode still follows the scan, no ghosting.
- Hex table, active-low {g..a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
- Outputs seg, dp, an and frame_done are all registered: one cycle of latency from index/PWM state.
  - seg and an change on the same edge, so no segment data ever appears on the wrong digit.
- Brightness is sampled every cycle, with no buffering.
- Reset mid-frame: immediate dark outputs and all counters cleared. Any pending load is lost.

Decomposition:
- Shared package sseg_pkg:
  - SEG_BLANK = 7'h7F
  - hex-to-segment function/table
  - constant for index width = clog2(NUM_DIGITS), minimum 1
- One sub-module: sseg_hex_decode (combinational nibble -> 7-bit active-low pattern).
- The top contains the prescaler, scan index, PWM, double buffer, LZ logic and output registers.

Test Plan:
All scenarios use REFRESH_DIV=4, NUM_DIGITS=4, DUTY_WIDTH=4.
- Reset release, no load -> an=4'hF, seg=7'h7F, dp=1 for several frames; frame_done pulses every 16 cycles.
- load digits_in=16'h3A0F, blank=0, dp=4'b0100, brightness=4'hF -> after the next frame boundary:
  - an cycles 1110,1101,1011,0111, each for 4 cycles.
  - seg = 0001110 (F), 1000000 (0), 0001000 (A), 0110000 (3).
  - dp = 0 only while an=1011.
- Load mid-frame while digit 1 is shown -> displayed values are unchanged until the frame_done cycle; load at the exact boundary cycle -> the new values show in the immediately following frame.
- LZ_SUPPRESS=1, digits_in=16'h0050 -> digits 3 and 2 dark (seg=7'h7F), digit 1 shows 5, digit 0 shows 0; digits_in=16'h0000 -> only digit 0 shows 0.
- brightness=4 -> the active anode is low for exactly 4 of every 16 cycles; brightness=0 -> an stays 4'hF.
- Assert reset mid-frame with data displayed -> outputs go dark asynchronously; after release the display stays dark until a new load plus a frame boundary.
